// File: rtl/id_ex_ctrl_pipe_pkg.sv
// Shared definitions for the ID/EX control pipeline: opcodes, FSM states, control bundle.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package id_ex_pkg;

  localparam logic [3:0] OP_LW   = 4'd8;
  localparam logic [3:0] OP_SW   = 4'd9;
  localparam logic [3:0] OP_LHB  = 4'd10;
  localparam logic [3:0] OP_LLB  = 4'd11;
  localparam logic [3:0] OP_B    = 4'd12;
  localparam logic [3:0] OP_CALL = 4'd13;
  localparam logic [3:0] OP_RET  = 4'd14;
  localparam logic [3:0] OP_HLT  = 4'd15;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } state_e;

  // Field order here is the order the bench packs observed outputs in.
  typedef struct packed {
    logic alu_src;
    logic mem_to_reg;
    logic mem_read;
    logic mem_write;
    logic branch;
    logic call;
    logic ret;
    logic hlt;
    logic reg_write;
    logic z_upd;
    logic n_upd;
    logic v_upd;
  } ctrl_t;

  // A bubble clears every control bit, reg_write included.
  localparam ctrl_t BUBBLE = '0;

endpackage

// File: rtl/id_ex_ctrl_pipe_if.sv
// ID-side inputs and EX-side registered control outputs of the ID/EX control pipeline.
// Ports: master drives id_valid/id_inst/stall_in/flush and observes id_stall, ex_* and halted;
//        slave (the pipeline) is the mirror image.
interface id_ex_ctrl_pipe_if #(
  parameter int INST_W = 16,
  parameter int RA_W   = 4
);
  logic              id_valid;
  logic [INST_W-1:0] id_inst;
  logic              stall_in;
  logic              flush;
  logic              id_stall;
  logic              ex_valid;
  logic              ex_alu_src;
  logic              ex_mem_to_reg;
  logic              ex_mem_read;
  logic              ex_mem_write;
  logic              ex_branch;
  logic              ex_call;
  logic              ex_ret;
  logic              ex_hlt;
  logic              ex_reg_write;
  logic              ex_z_upd;
  logic              ex_n_upd;
  logic              ex_v_upd;
  logic [RA_W-1:0]   ex_rs;
  logic [RA_W-1:0]   ex_rt;
  logic [RA_W-1:0]   ex_rd;
  logic              halted;

  modport master (
    output id_valid, id_inst, stall_in, flush,
    input  id_stall, ex_valid, ex_alu_src, ex_mem_to_reg, ex_mem_read, ex_mem_write,
           ex_branch, ex_call, ex_ret, ex_hlt, ex_reg_write, ex_z_upd, ex_n_upd,
           ex_v_upd, ex_rs, ex_rt, ex_rd, halted
  );

  modport slave (
    input  id_valid, id_inst, stall_in, flush,
    output id_stall, ex_valid, ex_alu_src, ex_mem_to_reg, ex_mem_read, ex_mem_write,
           ex_branch, ex_call, ex_ret, ex_hlt, ex_reg_write, ex_z_upd, ex_n_upd,
           ex_v_upd, ex_rs, ex_rt, ex_rd, halted
  );
endinterface

// File: rtl/id_ex_ctrl_pipe_inst_ctrl_decode.sv
// Pure combinational decode of one instruction into the control bundle and register addresses.
// Latency: 0 cycles. Backpressure: none (no state).
// Ports: inst_i in; ctrl_o, rs_o/rt_o/rd_o, rs_used_o/rt_used_o out.
module inst_ctrl_decode
  import id_ex_pkg::*;
#(
  parameter int INST_W   = 16,
  parameter int RA_W     = 4,
  parameter int LINK_REG = 15
) (
  input  logic [INST_W-1:0] inst_i,
  output ctrl_t             ctrl_o,
  output logic [RA_W-1:0]   rs_o,
  output logic [RA_W-1:0]   rt_o,
  output logic [RA_W-1:0]   rd_o,
  output logic              rs_used_o,
  output logic              rt_used_o
);
  logic [3:0]      op;
  logic [RA_W-1:0] fld_hi, fld_mid, fld_lo;

  assign op      = inst_i[INST_W-1 -: 4];
  assign fld_hi  = inst_i[3*RA_W-1:2*RA_W];
  assign fld_mid = inst_i[2*RA_W-1:RA_W];
  assign fld_lo  = inst_i[RA_W-1:0];

  always_comb begin
    ctrl_o           = BUBBLE;
    ctrl_o.reg_write = 1'b1;
    case (op)
      4'd5, 4'd6, 4'd7, OP_LHB, OP_LLB: ctrl_o.alu_src = 1'b1;
      OP_LW: begin
        ctrl_o.alu_src    = 1'b1;
        ctrl_o.mem_read   = 1'b1;
        ctrl_o.mem_to_reg = 1'b1;
      end
      OP_SW: begin
        ctrl_o.alu_src   = 1'b1;
        ctrl_o.mem_write = 1'b1;
        ctrl_o.reg_write = 1'b0;
      end
      OP_B: begin
        ctrl_o.branch    = 1'b1;
        ctrl_o.reg_write = 1'b0;
      end
      OP_CALL: ctrl_o.call = 1'b1;
      OP_RET: begin
        ctrl_o.ret       = 1'b1;
        ctrl_o.reg_write = 1'b0;
      end
      OP_HLT:  ctrl_o.hlt = 1'b1;
      default: ;
    endcase
    // Only ALU ops touch flags; memory/control-flow ops leave them alone.
    ctrl_o.z_upd = (op <= 4'd7);
    ctrl_o.n_upd = (op == 4'd0) || (op == 4'd2);
    ctrl_o.v_upd = (op == 4'd0) || (op == 4'd2);
  end

  // LHB reads its own destination; LW/SW carry the data register in the high field.
  assign rs_o      = (op == OP_LHB) ? fld_hi : fld_mid;
  assign rt_o      = (op == OP_LW || op == OP_SW) ? fld_hi : fld_lo;
  assign rd_o      = ctrl_o.call ? RA_W'(LINK_REG) : fld_hi;
  assign rs_used_o = (op <= OP_LHB);
  assign rt_used_o = (op <= 4'd4) || (op == OP_SW);

endmodule

// File: rtl/id_ex_ctrl_pipe.sv
// ID/EX control pipeline register with stall, flush, load-use bubble and halt-drain FSM.
// Latency: 1 cycle ID->EX. Backpressure: stall_in freezes ID/EX; id_stall holds PC and IF/ID.
// Ports: clk, rst_n (sync, active low), bus (id_ex_ctrl_pipe_if.slave).
// Option: define CTRL_HAZARD_DETECT_EN for hardware load-use detection; otherwise the
// compiler must schedule around load-use hazards.
module id_ex_ctrl_pipe
  import id_ex_pkg::*;
#(
  parameter int INST_W    = 16,
  parameter int RA_W      = 4,
  parameter int LINK_REG  = 15,
  parameter int DRAIN_CYC = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  id_ex_ctrl_pipe_if.slave  bus
);
  ctrl_t           dec_ctrl;
  logic [RA_W-1:0] dec_rs, dec_rt, dec_rd;
  logic            dec_rs_used, dec_rt_used;
  logic            hazard;

  state_e          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            ex_valid_q, ex_valid_d;
  ctrl_t           ex_ctrl_q, ex_ctrl_d;
  logic [RA_W-1:0] ex_rs_q, ex_rs_d, ex_rt_q, ex_rt_d, ex_rd_q, ex_rd_d;

  inst_ctrl_decode #(
    .INST_W  (INST_W),
    .RA_W    (RA_W),
    .LINK_REG(LINK_REG)
  ) u_dec (
    .inst_i   (bus.id_inst),
    .ctrl_o   (dec_ctrl),
    .rs_o     (dec_rs),
    .rt_o     (dec_rt),
    .rd_o     (dec_rd),
    .rs_used_o(dec_rs_used),
    .rt_used_o(dec_rt_used)
  );

`ifdef CTRL_HAZARD_DETECT_EN
  assign hazard = ex_valid_q && ex_ctrl_q.mem_read && (ex_rd_q != '0) &&
                  ((dec_rs_used && dec_rs == ex_rd_q) || (dec_rt_used && dec_rt == ex_rd_q));
`else
  logic unused_hz;
  assign hazard    = 1'b0;
  assign unused_hz = dec_rs_used ^ dec_rt_used;
`endif

  // Drain FSM; a stall freezes it along with ID/EX. HALTED is entered on the edge the
  // counter reaches zero, so halted rises DRAIN_CYC unstalled edges after hlt reaches EX.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      RUN: begin
        if (ex_valid_q && ex_ctrl_q.hlt && !bus.stall_in) begin
          state_d = DRAIN;
          cnt_d   = 4'(DRAIN_CYC - 1);
        end
      end
      DRAIN: begin
        if (!bus.stall_in) begin
          if (cnt_q <= 4'd1) state_d = HALTED;
          cnt_d = (cnt_q == 4'd0) ? 4'd0 : cnt_q - 4'd1;
        end
      end
      HALTED:  ;
      default: state_d = RUN;
    endcase
  end

  // ID/EX next state; in DRAIN the flush is irrelevant since only bubbles load anyway.
  always_comb begin
    ex_valid_d = ex_valid_q;
    ex_ctrl_d  = ex_ctrl_q;
    ex_rs_d    = ex_rs_q;
    ex_rt_d    = ex_rt_q;
    ex_rd_d    = ex_rd_q;
    if (state_q == HALTED ||
        (!bus.stall_in && (state_q == DRAIN || bus.flush || hazard || !bus.id_valid))) begin
      ex_valid_d = 1'b0;
      ex_ctrl_d  = BUBBLE;
      ex_rs_d    = '0;
      ex_rt_d    = '0;
      ex_rd_d    = '0;
    end else if (!bus.stall_in) begin
      ex_valid_d = 1'b1;
      ex_ctrl_d  = dec_ctrl;
      ex_rs_d    = dec_rs;
      ex_rt_d    = dec_rt;
      ex_rd_d    = dec_rd;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= RUN;
      cnt_q      <= 4'd0;
      ex_valid_q <= 1'b0;
      ex_ctrl_q  <= BUBBLE;
      ex_rs_q    <= '0;
      ex_rt_q    <= '0;
      ex_rd_q    <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ex_valid_q <= ex_valid_d;
      ex_ctrl_q  <= ex_ctrl_d;
      ex_rs_q    <= ex_rs_d;
      ex_rt_q    <= ex_rt_d;
      ex_rd_q    <= ex_rd_d;
    end
  end

  // A flush kills the ID instruction, so IF/ID may advance even if it looked hazardous.
  assign bus.id_stall = rst_n && ((state_q != RUN) || bus.stall_in || (!bus.flush && hazard));

  assign bus.ex_valid      = ex_valid_q;
  assign bus.ex_alu_src    = ex_ctrl_q.alu_src;
  assign bus.ex_mem_to_reg = ex_ctrl_q.mem_to_reg;
  assign bus.ex_mem_read   = ex_ctrl_q.mem_read;
  assign bus.ex_mem_write  = ex_ctrl_q.mem_write;
  assign bus.ex_branch     = ex_ctrl_q.branch;
  assign bus.ex_call       = ex_ctrl_q.call;
  assign bus.ex_ret        = ex_ctrl_q.ret;
  assign bus.ex_hlt        = ex_ctrl_q.hlt;
  assign bus.ex_reg_write  = ex_ctrl_q.reg_write;
  assign bus.ex_z_upd      = ex_ctrl_q.z_upd;
  assign bus.ex_n_upd      = ex_ctrl_q.n_upd;
  assign bus.ex_v_upd      = ex_ctrl_q.v_upd;
  assign bus.ex_rs         = ex_rs_q;
  assign bus.ex_rt         = ex_rt_q;
  assign bus.ex_rd         = ex_rd_q;
  assign bus.halted        = (state_q == HALTED);

endmodule

// File: tb/tb_id_ex_ctrl_pipe.sv
// Bench for id_ex_ctrl_pipe: table vectors, directed corner sequences and random traffic
// checked against a behavioural model that keeps the EX instruction and re-decodes it.
module tb_id_ex_ctrl_pipe;
  localparam int DRAIN_CYC = 3;
`ifdef CTRL_HAZARD_DETECT_EN
  localparam bit HZ = 1'b1;
`else
  localparam bit HZ = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  id_ex_ctrl_pipe_if #(.INST_W(16), .RA_W(4)) bus_if ();

  id_ex_ctrl_pipe #(
    .INST_W(16), .RA_W(4), .LINK_REG(15), .DRAIN_CYC(DRAIN_CYC)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus_if)
  );

  int checks = 0;
  int errors = 0;
  logic seen_stall;

  // Model state: the instruction sitting in EX plus halt bookkeeping.
  bit          m_valid, m_draining, m_halted;
  logic [15:0] m_inst;
  int          m_edges;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [11:0] ref_ctrl(input logic [15:0] inst);
    int op;
    logic n;
    op = int'(inst[15:12]);
    n  = op inside {0, 2};
    return {op inside {[5:11]}, op == 8, op == 8, op == 9, op == 12, op == 13, op == 14,
            op == 15, !(op inside {9, 12, 14}), op <= 7, n, n};
  endfunction
  function automatic logic [3:0] ref_rs(input logic [15:0] i);
    return (i[15:12] == 4'd10) ? i[11:8] : i[7:4];
  endfunction
  function automatic logic [3:0] ref_rt(input logic [15:0] i);
    return (i[15:12] inside {4'd8, 4'd9}) ? i[11:8] : i[3:0];
  endfunction
  function automatic logic [3:0] ref_rd(input logic [15:0] i);
    return (i[15:12] == 4'd13) ? 4'd15 : i[11:8];
  endfunction

  function automatic bit m_hazard(input logic [15:0] id);
    int op;
    logic [3:0] r;
    op = int'(id[15:12]);
    r  = ref_rd(m_inst);
    return HZ && m_valid && m_inst[15:12] == 4'd8 && r != 0 &&
           ((op <= 10 && ref_rs(id) == r) || ((op <= 4 || op == 9) && ref_rt(id) == r));
  endfunction

  function automatic logic [11:0] dut_ctrl();
    return {bus_if.ex_alu_src, bus_if.ex_mem_to_reg, bus_if.ex_mem_read, bus_if.ex_mem_write,
            bus_if.ex_branch, bus_if.ex_call, bus_if.ex_ret, bus_if.ex_hlt,
            bus_if.ex_reg_write, bus_if.ex_z_upd, bus_if.ex_n_upd, bus_if.ex_v_upd};
  endfunction

  task automatic model_step();
    bit hz, was_draining;
    hz           = m_hazard(bus_if.id_inst);
    was_draining = m_draining;
    if (!rst_n) begin
      m_valid = 0; m_inst = '0; m_draining = 0; m_halted = 0; m_edges = 0;
    end else if (m_halted) begin
      m_valid = 0;
    end else if (!bus_if.stall_in) begin
      if (m_draining) begin
        m_edges++;
        if (m_edges >= DRAIN_CYC) begin m_halted = 1; m_draining = 0; end
      end else if (m_valid && m_inst[15:12] == 4'd15) begin
        m_draining = 1; m_edges = 1;
      end
      if (was_draining || bus_if.flush || hz || !bus_if.id_valid) m_valid = 0;
      else begin m_valid = 1; m_inst = bus_if.id_inst; end
    end
  endtask

  // Called at a negedge: drive, check id_stall, clock, check registered outputs.
  task automatic step(input logic v, input logic [15:0] inst, input logic st, input logic fl,
                      input string tag);
    bit exp_stall;
    bus_if.id_valid = v;
    bus_if.id_inst  = inst;
    bus_if.stall_in = st;
    bus_if.flush    = fl;
    #1;
    exp_stall  = rst_n && (m_halted || m_draining || st || (!fl && m_hazard(inst)));
    seen_stall = bus_if.id_stall;
    chk({tag, "_id_stall"}, 32'(seen_stall), 32'(exp_stall));
    @(posedge clk);
    model_step();
    @(negedge clk);
    chk({tag, "_ex_valid"}, 32'(bus_if.ex_valid), 32'(m_valid));
    chk({tag, "_ctrl"}, 32'(dut_ctrl()), m_valid ? 32'(ref_ctrl(m_inst)) : 32'd0);
    chk({tag, "_regs"}, 32'({bus_if.ex_rs, bus_if.ex_rt, bus_if.ex_rd}),
        m_valid ? 32'({ref_rs(m_inst), ref_rt(m_inst), ref_rd(m_inst)}) : 32'd0);
    chk({tag, "_halted"}, 32'(bus_if.halted), 32'(m_halted));
  endtask

  typedef struct {
    logic        v;
    logic [15:0] inst;
    logic [11:0] ctrl;
    logic [3:0]  rs, rt, rd;
  } vec_t;

  initial begin
    vec_t vt[13];
    // ctrl bit order: alu_src mem_to_reg mem_read mem_write branch call ret hlt reg_write z n v
    vt[0]  = '{1'b1, 16'h8123, 12'b1110_0000_1000, 4'h2, 4'h1, 4'h1};
    vt[1]  = '{1'b1, 16'hD300, 12'b0000_0100_1000, 4'h0, 4'h0, 4'hF};
    vt[2]  = '{1'b1, 16'h0123, 12'b0000_0000_1111, 4'h2, 4'h3, 4'h1};
    vt[3]  = '{1'b1, 16'h2456, 12'b0000_0000_1111, 4'h5, 4'h6, 4'h4};
    vt[4]  = '{1'b1, 16'h1789, 12'b0000_0000_1100, 4'h8, 4'h9, 4'h7};
    vt[5]  = '{1'b1, 16'h5ABC, 12'b1000_0000_1100, 4'hB, 4'hC, 4'hA};
    vt[6]  = '{1'b1, 16'h9ABC, 12'b1001_0000_0000, 4'hB, 4'hA, 4'hA};
    vt[7]  = '{1'b1, 16'hA3CD, 12'b1000_0000_1000, 4'h3, 4'hD, 4'h3};
    vt[8]  = '{1'b1, 16'hB3CD, 12'b1000_0000_1000, 4'hC, 4'hD, 4'h3};
    vt[9]  = '{1'b1, 16'hC456, 12'b0000_1000_0000, 4'h5, 4'h6, 4'h4};
    vt[10] = '{1'b1, 16'hE789, 12'b0000_0010_0000, 4'h8, 4'h9, 4'h7};
    vt[11] = '{1'b1, 16'h7111, 12'b1000_0000_1100, 4'h1, 4'h1, 4'h1};
    vt[12] = '{1'b0, 16'h0123, 12'b0000_0000_0000, 4'h0, 4'h0, 4'h0};

    m_valid = 0; m_draining = 0; m_halted = 0; m_inst = '0; m_edges = 0;
    rst_n = 1'b0;
    bus_if.id_valid = 1'b0; bus_if.id_inst = '0; bus_if.stall_in = 1'b0; bus_if.flush = 1'b0;
    @(negedge clk);

    // Reset with a live LW in ID, then first load after release.
    step(1, 16'h8123, 0, 0, "rst0");
    step(1, 16'h8123, 0, 0, "rst1");
    chk("rst_ex_valid", 32'(bus_if.ex_valid), 0);
    chk("rst_ctrl", 32'(dut_ctrl()), 0);
    rst_n = 1'b1;
    step(1, 16'h8123, 0, 0, "rel");
    chk("rel_mem_read", 32'(bus_if.ex_mem_read), 1);
    chk("rel_mem_to_reg", 32'(bus_if.ex_mem_to_reg), 1);
    chk("rel_rs_rt_rd", 32'({bus_if.ex_rs, bus_if.ex_rt, bus_if.ex_rd}), 32'h211);

    // Table vectors, each loaded behind a bubble so no hazard is pending.
    for (int i = 0; i < 13; i++) begin
      step(0, 16'h0000, 0, 0, "tbl_bub");
      step(vt[i].v, vt[i].inst, 0, 0, "tbl");
      chk($sformatf("tbl%0d_valid", i), 32'(bus_if.ex_valid), 32'(vt[i].v));
      chk($sformatf("tbl%0d_ctrl", i), 32'(dut_ctrl()), 32'(vt[i].ctrl));
      chk($sformatf("tbl%0d_regs", i), 32'({bus_if.ex_rs, bus_if.ex_rt, bus_if.ex_rd}),
          32'({vt[i].rs, vt[i].rt, vt[i].rd}));
    end

    // Stall freezes EX while ID changes; then flush kills the ID instruction.
    step(1, 16'h0123, 0, 0, "sf_load");
    for (int i = 0; i < 3; i++) begin
      step(1, 16'h2000 + 16'(i * 16'h0111), 1, 0, "sf_stall");
      chk("sf_frozen_ctrl", 32'(dut_ctrl()), 32'(12'b0000_0000_1111));
      chk("sf_frozen_rd", 32'(bus_if.ex_rd), 1);
      chk("sf_id_stall", 32'(seen_stall), 1);
    end
    step(1, 16'h0123, 0, 1, "sf_flush");
    chk("sf_flush_valid", 32'(bus_if.ex_valid), 0);
    chk("sf_flush_rw", 32'(bus_if.ex_reg_write), 0);
    chk("sf_flush_id_stall", 32'(seen_stall), 0);

    // Load-use: LW r5 then ADD reading r5.
    step(0, 16'h0000, 0, 0, "lu_bub");
    step(1, 16'h8523, 0, 0, "lu_lw");
    step(1, 16'h0456, 0, 0, "lu1");
    chk("lu_id_stall", 32'(seen_stall), 32'(HZ));
    chk("lu_ex_valid", 32'(bus_if.ex_valid), 32'(!HZ));
    step(1, 16'h0456, 0, 0, "lu2");
    chk("lu2_id_stall", 32'(seen_stall), 0);
    chk("lu2_n_upd", 32'(bus_if.ex_n_upd), 1);
    chk("lu2_rd", 32'(bus_if.ex_rd), 4);

    // Random traffic (no hlt), small register fields to provoke hazards.
    for (int i = 0; i < 400; i++) begin
      logic [15:0] ri;
      ri = {4'($urandom_range(0, 14)), 4'($urandom_range(0, 3)),
            4'($urandom_range(0, 3)), 4'($urandom_range(0, 3))};
      step($urandom_range(0, 3) != 0, ri, $urandom_range(0, 5) == 0,
           $urandom_range(0, 7) == 0, "rnd");
    end

    // Halt killed by flush in ID never halts.
    step(0, 16'h0000, 0, 0, "kh_bub");
    step(1, 16'hF000, 0, 1, "kh_flush");
    for (int i = 0; i < 5; i++) begin
      step(0, 16'h0000, 0, 0, "kh_idle");
      chk("kh_halted", 32'(bus_if.halted), 0);
      chk("kh_run", 32'(seen_stall), 0);
    end

    // Reset in the middle of DRAIN returns to RUN.
    step(1, 16'hF000, 0, 0, "rd_hlt");
    step(0, 16'h0000, 0, 0, "rd_drain");
    rst_n = 1'b0;
    step(0, 16'h0000, 0, 0, "rd_rst");
    rst_n = 1'b1;
    step(0, 16'h0000, 0, 0, "rd_after");
    chk("rd_run_id_stall", 32'(seen_stall), 0);
    chk("rd_halted", 32'(bus_if.halted), 0);

    // Halt with one stalled drain cycle: halted exactly 4 edges after hlt reaches EX.
    step(0, 16'h0000, 0, 0, "h_bub");
    step(1, 16'hF000, 0, 0, "h_e0");
    chk("h_e0_hlt", 32'(bus_if.ex_hlt), 1);
    step(1, 16'h0123, 0, 0, "h_e1");
    chk("h_e1_halted", 32'(bus_if.halted), 0);
    step(1, 16'h0123, 1, 0, "h_e2");
    chk("h_e2_halted", 32'(bus_if.halted), 0);
    step(1, 16'h0123, 0, 0, "h_e3");
    chk("h_e3_halted", 32'(bus_if.halted), 0);
    chk("h_e3_id_stall", 32'(seen_stall), 1);
    step(1, 16'h0123, 0, 0, "h_e4");
    chk("h_e4_halted", 32'(bus_if.halted), 1);
    for (int i = 0; i < 4; i++) begin
      step(1, 16'h1456, 0, i[0], "h_post");
      chk("h_post_valid", 32'(bus_if.ex_valid), 0);
      chk("h_post_halted", 32'(bus_if.halted), 1);
      chk("h_post_id_stall", 32'(seen_stall), 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/id_ex_ctrl_pipe.md
Name: id_ex_ctrl_pipe

Overview:
- Parametrised successor to the combinational instruction control decoder for the 16-bit ISA.
- Decodes the instruction in ID and registers the control bundle into the ID/EX pipeline register.
- Adds downstream stall, branch flush, load-use hazard bubble insertion and a halt-drain state machine.
- Sits between the IF/ID register and the EX stage.

Parameters:
- INST_W, 16, instruction width; opcode is always inst[INST_W-1:INST_W-4].
- RA_W, 4, register address width.
- LINK_REG, 15, destination register forced for call.
- DRAIN_CYC, 3, cycles after hlt enters EX before halted asserts (1..15).

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- id_valid  in  1  ID holds a real instruction
- id_inst  in  INST_W  instruction in ID
- stall_in  in  1  downstream stall (cache miss); freezes ID/EX
- flush  in  1  taken branch/call/ret; kills the ID instruction
- id_stall  out  1  hold PC and IF/ID this cycle
- ex_valid  out  1  EX holds a real instruction
- ex_alu_src, ex_mem_to_reg, ex_mem_read, ex_mem_write, ex_branch, ex_call, ex_ret, ex_hlt, ex_reg_write  out  1 each  registered control
- ex_z_upd, ex_n_upd, ex_v_upd  out  1 each  flag-update enables
- ex_rs, ex_rt, ex_rd  out  RA_W each  registered register addresses
- halted  out  1  core halted (sticky)

Behaviour:
- Decode (combinational, ID):
  - 5,6,7,10,11: alu_src.
  - 8: alu_src, mem_read, mem_to_reg.
  - 9: alu_src, mem_write, reg_write=0.
  - 12: branch, reg_write=0.
  - 13: call.
  - 14: ret, reg_write=0.
  - 15: hlt.
  - Otherwise reg_write=1 and everything else 0.
- Address decode:
  - rs = inst[11:8] for opcode 10, else inst[7:4].
  - rt = inst[11:8] for opcodes 8/9, else inst[3:0].
  - rd = LINK_REG if call, else inst[11:8].
- Flag update:
  - z_upd=1 for opcodes 0-7 only.
  - n_upd=v_upd=1 for opcodes 0 and 2 only.
  - All flag-update enables are 0 for memory, branch, call, ret and hlt (new vs. previous generation).
- Source usage, for hazard checks only:
  - rs is used for opcodes 0-10.
  - rt is used for opcodes 0-4 and 9.
- Reset: all ex_* outputs, id_stall and halted are 0; FSM enters RUN; drain counter is 0.
- Update priority each clk edge: reset > halted > stall_in > flush > hazard > load.
  - halted: ex_valid=0, all control 0, id_stall=1.
  - stall_in: ID/EX holds every value; id_stall=1.
  - flush: bubble loaded (ex_valid=0, all control 0, addresses 0); id_stall=0.
  - hazard: bubble loaded; id_stall=1 (combinational, same cycle).
  - load: ex_* <= decode, gated by id_valid; a bubble if id_valid=0.
- Latency: one cycle ID to EX.
- Bubble: every control bit 0, including reg_write.
- FSM states:
  - RUN -> DRAIN when ex_valid && ex_hlt && !stall_in. The counter loads DRAIN_CYC-1.
  - DRAIN: load is blocked, so bubbles only are inserted; id_stall=1. The counter decrements on cycles without stall_in.
  - DRAIN -> HALTED when the counter is 0.
  - HALTED is terminal until reset; halted=1.
- flush in DRAIN or HALTED is ignored.
- hlt in ID together with flush is killed and never halts.
- rst_n low mid-DRAIN returns to RUN next edge.

Optional Feature:
- Macro: CTRL_HAZARD_DETECT_EN.
- Defined: load-use hazard detection is active. The hazard condition is ex_valid && ex_mem_read && ex_rd != 0 && (rs used && rs==ex_rd || rt used && rt==ex_rd). On a hazard, one bubble is inserted and id_stall is held for one cycle.
- Not defined: the hazard term is constant 0, and software scheduling is required.

Decomposition:
- Shared package id_ex_pkg:
  - Opcode localparams (OP_LW=8, OP_SW=9, OP_LHB=10, OP_LLB=11, OP_B=12, OP_CALL=13, OP_RET=14, OP_HLT=15).
  - FSM state typedef {RUN, DRAIN, HALTED}.
  - Packed ctrl_t struct and BUBBLE constant.
- Natural sub-module: inst_ctrl_decode, the pure combinational decode producing ctrl_t plus rs/rt/rd and the used flags.
- The pipeline register, hazard logic and FSM stay in the top module.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with id_valid=1, id_inst=16'h8123 -> all ex_* =0, halted=0, id_stall=0; after release, next edge ex_mem_read=1, ex_mem_to_reg=1, ex_rd=1, ex_rt=1, ex_rs=2.
- Call: id_inst=16'hD300 -> ex_call=1, ex_rd=15, ex_reg_write=1, ex_z_upd=0.
- Stall/flush: stall_in=1 for 3 cycles with the ID instruction changing -> ex_* frozen, id_stall=1. Then flush=1 with id_inst=16'h0123 -> ex_valid=0, ex_reg_write=0.
- Load-use (macro defined): LW 16'h8523 then ADD 16'h0456 -> one cycle with id_stall=1 and an EX bubble, then the ADD loads with ex_n_upd=1. The same sequence with the macro undefined gives no stall.
- Halt, DRAIN_CYC=3: 16'hF000 loaded, stall_in=1 for one DRAIN cycle -> halted asserts exactly 4 cycles after hlt reaches EX. A later flush or new instructions leave ex_valid=0.
- Killed halt: hlt in ID with flush=1 -> halted stays 0 and the FSM remains in RUN.
